// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the two sides of the fetch stage.
//               - Instruction-memory request/ready handshake.
//               - Decode-side controls: stall, branch, jump.
//               - IF/ID register outputs toward decode.
//               master : the fetch unit.
//               slave  : memory plus decode (the environment).
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req;       // fetch request, qualifies imem_addr
    logic [31:0] imem_addr;      // byte address of requested word (= PC)
    logic        imem_ready;     // imem_rdata is valid for imem_addr
    logic [31:0] imem_rdata;     // instruction word from memory
    logic        stall;          // decode cannot accept a new instruction
    logic        branch_taken;   // redirect to branch_target
    logic [31:0] branch_target;  // absolute word-aligned branch target
    logic        jump;           // redirect to the J-type target
    logic [25:0] jump_index;     // J-type index field
    logic [31:0] instr;          // IF/ID instruction (0 when invalid)
    logic [31:0] pc_plus4;       // IF/ID PC+4 of instr
    logic        instr_valid;    // IF/ID holds a real instruction

    modport master (
        output imem_req, imem_addr, instr, pc_plus4, instr_valid,
        input  imem_ready, imem_rdata, stall, branch_taken, branch_target,
               jump, jump_index
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc_plus4, instr_valid,
        output imem_ready, imem_rdata, stall, branch_taken, branch_target,
               jump, jump_index
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage and IF/ID pipeline register.
//               - Holds the PC and fetches words over a req/ready handshake.
//               - A one-entry skid buffer absorbs the word that arrives on
//                 the cycle decode stalls.
//               - Branch and jump redirects squash IF/ID, which inserts
//                 one bubble.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - fetch_unit_if.master (memory handshake, decode
//                      controls, IF/ID outputs)
// Parameters  : RESET_PC - PC value loaded on reset
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_unit_if.master       bus
);

    typedef enum logic [0:0] {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic [31:0] w_pc_inc;
    logic        w_redirect;
    logic [31:0] w_target;

    // 32-bit modulo increment: 0xFFFF_FFFC wraps to 0.
    assign w_pc_inc   = pc_q + 32'd4;
    assign w_redirect = bus.jump | bus.branch_taken;
    // Jump takes its region bits from the instruction currently in IF/ID.
    assign w_target   = bus.jump ? {pc4_q[31:28], bus.jump_index, 2'b00}
                                 : bus.branch_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (w_redirect) begin
            // Redirect overrides stall and handshake; any word returned
            // this cycle and any skid contents are dropped.
            pc_d         = w_target;
            instr_d      = 32'd0;
            valid_d      = 1'b0;
            skid_instr_d = 32'd0;
            skid_pc4_d   = 32'd0;
            state_d      = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready) begin
                        pc_d = w_pc_inc;
                        if (!bus.stall) begin
                            instr_d = bus.imem_rdata;
                            pc4_d   = w_pc_inc;
                            valid_d = 1'b1;
                        end else begin
                            // Decode is stalled: park the word, stop fetching.
                            skid_instr_d = bus.imem_rdata;
                            skid_pc4_d   = w_pc_inc;
                            state_d      = BUFFERED;
                        end
                    end else if (!bus.stall) begin
                        // Memory not ready and decode can take something:
                        // hand it a nop bubble.
                        instr_d = 32'd0;
                        valid_d = 1'b0;
                    end
                end
                BUFFERED: begin
                    if (!bus.stall) begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Request is gated by rst directly so it drops the instant reset asserts.
    assign bus.imem_req    = (state_q == FETCH) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.pc_plus4    = pc4_q;
    assign bus.instr_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
//               Memory returns f(addr) = addr ^ 32'hDEAD_0000.
//               Inputs change 1ns after a rising edge; outputs are
//               checked at that same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
        chk({tag, ".instr"},    bus.instr,       ins);
        chk({tag, ".pc_plus4"}, bus.pc_plus4,    p4);
        chk({tag, ".valid"},    {31'd0, bus.instr_valid}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr, input logic req);
        chk({tag, ".addr"}, bus.imem_addr, addr);
        chk({tag, ".req"},  {31'd0, bus.imem_req}, {31'd0, req});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.imem_ready    = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'd0;

        // Reset state
        tick();
        chk_ifid("reset", 32'd0, 32'd0, 1'b0);
        chk_req("reset", 32'h40, 1'b0);
        rst = 1'b0;
        #1;
        chk_req("first_req", 32'h40, 1'b1);

        // Back-to-back fetch with ready tied high
        tick();
        chk_ifid("e1", mem_word(32'h40), 32'h44, 1'b1);
        chk_req("e1", 32'h44, 1'b1);
        tick();
        chk_ifid("e2", mem_word(32'h44), 32'h48, 1'b1);
        chk_req("e2", 32'h48, 1'b1);

        // Memory not ready for two cycles: bubbles, PC held
        bus.imem_ready = 1'b0;
        tick();
        chk_ifid("nr1", 32'd0, 32'h48, 1'b0);
        chk_req("nr1", 32'h48, 1'b1);
        tick();
        chk_ifid("nr2", 32'd0, 32'h48, 1'b0);
        chk_req("nr2", 32'h48, 1'b1);
        bus.imem_ready = 1'b1;
        tick();
        chk_ifid("resume", mem_word(32'h48), 32'h4C, 1'b1);
        chk_req("resume", 32'h4C, 1'b1);

        // Stall for three cycles: one word goes to skid, no further requests
        bus.stall = 1'b1;
        tick();
        chk_ifid("st1", mem_word(32'h48), 32'h4C, 1'b1);
        chk_req("st1", 32'h50, 1'b0);
        tick();
        chk_ifid("st2", mem_word(32'h48), 32'h4C, 1'b1);
        chk_req("st2", 32'h50, 1'b0);
        tick();
        chk_ifid("st3", mem_word(32'h48), 32'h4C, 1'b1);
        chk_req("st3", 32'h50, 1'b0);
        bus.stall = 1'b0;
        tick();
        chk_ifid("skid_out", mem_word(32'h4C), 32'h50, 1'b1);
        chk_req("skid_out", 32'h50, 1'b1);
        tick();
        chk_ifid("post_skid", mem_word(32'h50), 32'h54, 1'b1);
        chk_req("post_skid", 32'h54, 1'b1);

        // Branch while stalled with a full skid: skid word is discarded
        bus.stall = 1'b1;
        tick();
        chk_req("fill_skid", 32'h58, 1'b0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        tick();
        chk_ifid("br", 32'd0, 32'h54, 1'b0);
        chk_req("br", 32'h100, 1'b1);
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        tick();
        chk_ifid("br_tgt", mem_word(32'h100), 32'h104, 1'b1);
        chk_req("br_tgt", 32'h104, 1'b1);

        // Set pc_plus4 = 0x1000_0008, then jump and branch together
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h1000_0004;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        chk_ifid("pre_j", mem_word(32'h1000_0004), 32'h1000_0008, 1'b1);
        bus.jump          = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.jump_index    = 26'h000_0010;
        bus.branch_target = 32'h200;
        tick();
        chk_req("jump_wins", 32'h1000_0040, 1'b1);
        chk("jump_bubble", {31'd0, bus.instr_valid}, 32'd0);
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;

        // PC wrap at the top of the address space
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 1'b0;
        chk_req("at_top", 32'hFFFF_FFFC, 1'b1);
        tick();
        chk_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);
        chk_req("wrap", 32'h0, 1'b1);

        // Asynchronous reset mid-stall clears everything within the cycle
        bus.stall = 1'b1;
        tick();
        chk_req("pre_rst", 32'h4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_ifid("async_rst", 32'd0, 32'd0, 1'b0);
        chk_req("async_rst", 32'h40, 1'b0);
        bus.stall = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        chk_ifid("after_rst", mem_word(32'h40), 32'h44, 1'b1);
        chk_req("after_rst", 32'h44, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
